// File: rtl/recording_unit.sv
// Switch-activity recorder: synchronises fake_switch, times each level run in Div_CLK cycles
// and stores completed runs as {level, duration} segments readable through a comb port.
module recording_unit #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             Div_CLK,
    input  logic             Reset,
    input  logic             fake_switch,
    input  logic [AW-1:0]    rd_addr,
    output logic [CNT_W:0]   rd_data,
    output logic             cur_level,
    output logic [CNT_W-1:0] run_cnt,
    output logic [AW:0]      seg_count,
    output logic             rec_valid,
    output logic             last_level,
    output logic [CNT_W-1:0] last_duration,
    output logic             full,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [AW:0]      SegMax = (AW + 1)'(DEPTH);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic             level_edge;
    logic             store_en;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] run_cnt_d;
    logic [CNT_W:0]   mem [DEPTH];

    always_ff @(posedge Div_CLK or posedge Reset) begin
        if (Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1   <= fake_switch;
            sync2   <= sync1;
            level_q <= sync2;
        end
    end

    assign level_edge = (sync2 != level_q);
    assign full       = (seg_count == SegMax);
    assign store_en   = level_edge && !full;
    assign cur_level  = level_q;

    // The edge cycle itself is the first cycle of the new level, hence restart at 1.
    always_comb begin
        run_cnt_d = run_cnt;
        if (level_edge) begin
            run_cnt_d = CNT_W'(1);
        end else if (run_cnt != CntMax) begin
            run_cnt_d = run_cnt + 1'b1;
        end
    end

    always_ff @(posedge Div_CLK or posedge Reset) begin
        if (Reset) begin
            run_cnt       <= '0;
            seg_count     <= '0;
            wr_ptr        <= '0;
            last_level    <= 1'b0;
            last_duration <= '0;
            rec_valid     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            run_cnt   <= run_cnt_d;
            rec_valid <= level_edge;
            if (level_edge) begin
                last_level    <= level_q;
                last_duration <= run_cnt;
                if (full) begin
                    overflow <= 1'b1;
                end
            end
            if (store_en) begin
                wr_ptr    <= wr_ptr + 1'b1;
                seg_count <= seg_count + 1'b1;
            end
        end
    end

    always_ff @(posedge Div_CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            mem[wr_ptr] <= {level_q, run_cnt};
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_recording_unit.sv
// Randomised self-checking bench for recording_unit; expectations come from a run-length
// model of the sampled switch history.
module tb_recording_unit;

    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    logic             Div_CLK;
    logic             Reset;
    logic             fake_switch;
    logic [AW-1:0]    rd_addr;
    logic [CNT_W:0]   rd_data;
    logic             cur_level;
    logic [CNT_W-1:0] run_cnt;
    logic [AW:0]      seg_count;
    logic             rec_valid;
    logic             last_level;
    logic [CNT_W-1:0] last_duration;
    logic             full;
    logic             overflow;

    recording_unit #(
        .CNT_W(CNT_W),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .Div_CLK      (Div_CLK),
        .Reset        (Reset),
        .fake_switch  (fake_switch),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .cur_level    (cur_level),
        .run_cnt      (run_cnt),
        .seg_count    (seg_count),
        .rec_valid    (rec_valid),
        .last_level   (last_level),
        .last_duration(last_duration),
        .full         (full),
        .overflow     (overflow)
    );

    initial Div_CLK = 1'b0;
    always #50 Div_CLK = ~Div_CLK;

    int nvec = 0;
    int nmis = 0;

    // Reference model: history of level values as seen by the recorder, run-length encoded.
    logic           dl [$];
    logic           m_lvl;
    int             m_len;
    int             nseg;
    logic           e_last_lvl;
    int             e_last_dur;
    logic [CNT_W:0] mmem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
        return (n > CNTMAX) ? CNTMAX : n;
    endfunction

    task automatic model_reset();
        dl = {1'b0, 1'b0};  // the two reset-cleared stages ahead of the observed level
        m_lvl      = 1'b0;
        m_len      = 0;
        nseg       = 0;
        e_last_lvl = 1'b0;
        e_last_dur = 0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    endtask

    // Called at a negedge: drive x for one clock, then check at the following negedge.
    task automatic cycle(input logic x);
        logic hv;
        logic exp_rv;
        fake_switch = x;
        @(posedge Div_CLK);
        @(negedge Div_CLK);
        dl.push_back(x);
        hv     = dl.pop_front();
        exp_rv = 1'b0;
        if (m_len == 0) begin
            m_lvl = hv;
            m_len = 1;
        end else if (hv == m_lvl) begin
            m_len++;
        end else begin
            exp_rv     = 1'b1;
            e_last_lvl = m_lvl;
            e_last_dur = sat(m_len);
            if (nseg < DEPTH) mmem[nseg] = {m_lvl, CNT_W'(e_last_dur)};
            nseg++;
            m_lvl = hv;
            m_len = 1;
        end
        check("cur_level", 32'(cur_level), 32'(m_lvl));
        check("run_cnt", 32'(run_cnt), sat(m_len));
        check("rec_valid", 32'(rec_valid), 32'(exp_rv));
        check("seg_count", 32'(seg_count), (nseg > DEPTH) ? DEPTH : nseg);
        check("full", 32'(full), 32'(nseg >= DEPTH));
        check("overflow", 32'(overflow), 32'(nseg > DEPTH));
        check("last_level", 32'(last_level), 32'(e_last_lvl));
        check("last_duration", 32'(last_duration), e_last_dur);
    endtask

    task automatic run(input logic lvl, input int len);
        for (int i = 0; i < len; i++) cycle(lvl);
    endtask

    task automatic sweep_mem(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            check(tag, 32'(rd_data), 32'(mmem[a]));
        end
    endtask

    // Called at a negedge: reset asserts mid-cycle and must clear everything without a clock.
    task automatic mid_reset();
        #10;
        fake_switch = 1'b0;
        Reset       = 1'b1;
        #1;
        model_reset();
        check("rst_seg_count", 32'(seg_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_full", 32'(full), 0);
        check("rst_run_cnt", 32'(run_cnt), 0);
        check("rst_rec_valid", 32'(rec_valid), 0);
        check("rst_cur_level", 32'(cur_level), 0);
        check("rst_last_duration", 32'(last_duration), 0);
        sweep_mem("rst_rd_data");
        @(negedge Div_CLK);
        @(negedge Div_CLK);
        Reset = 1'b0;
    endtask

    initial begin
        logic lvl;
        Reset       = 1'b1;
        fake_switch = 1'b0;
        rd_addr     = '0;
        model_reset();

        // Reset held three cycles: everything idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge Div_CLK);
            check("reset_run_cnt", 32'(run_cnt), 0);
            check("reset_seg_count", 32'(seg_count), 0);
            check("reset_rec_valid", 32'(rec_valid), 0);
            check("reset_cur_level", 32'(cur_level), 0);
        end
        Reset = 1'b0;

        // 20 ms / 30 ms / 40 ms at 10 kHz, then a short closing run.
        run(1'b0, 198);
        run(1'b1, 300);
        run(1'b0, 400);
        run(1'b1, 5);
        check("dir_seg0", 32'(mmem[0]), {15'd0, 1'b0, 16'd200});
        check("dir_seg1_dut", 32'(dut.mem[1]), {15'd0, 1'b1, 16'd300});
        sweep_mem("dir_rd_data");

        // Random runs overfilling the 16-entry store.
        mid_reset();
        lvl = 1'b0;
        for (int r = 0; r < 20; r++) begin
            run(lvl, $urandom_range(1, 12));
            lvl = ~lvl;
        end
        run(lvl, 3);
        sweep_mem("ovf_rd_data");

        // Two segments recorded, then reset mid-run.
        mid_reset();
        run(1'b0, 5);
        run(1'b1, 5);
        run(1'b0, 3);
        check("two_segs", 32'(seg_count), 2);
        mid_reset();

        // A single very long level saturates the duration counter.
        run(1'b0, $urandom_range(1, 10));
        run(1'b1, CNTMAX + 500);
        run(1'b0, 5);
        check("sat_duration", 32'(last_duration), CNTMAX);
        sweep_mem("sat_rd_data");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
